// File: rtl/rv_go_pkg.sv
// rtl/rv_go_pkg.sv - shared rv_go definitions for the load/store unit
// Purpose: mem_op (RISC-V funct3) encodings, LSU FSM state encoding,
//          timeout counter width and the op legality helper.
// Ports:   none (package).
package rv_go_pkg;

  typedef enum logic [2:0] {
    MOP_B  = 3'b000,
    MOP_H  = 3'b001,
    MOP_W  = 3'b010,
    MOP_BU = 3'b100,
    MOP_HU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  // Wide enough for BUS_TIMEOUT up to 1023.
  localparam int TMO_CNT_W = 10;

  // Unsigned variants exist only for loads.
  function automatic logic op_legal(input logic [2:0] op, input logic is_store);
    logic l;
    case (op)
      MOP_B, MOP_H, MOP_W: l = 1'b1;
      MOP_BU, MOP_HU:      l = !is_store;
      default:             l = 1'b0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/rv_go_lsu_align.sv
// rtl/rv_go_lsu_align.sv - combinational byte-lane mask, shift and extend
// Purpose: lane logic for one access spanning up to two 32-bit beats.
// Ports:   i_op       mem_op of the access
//          i_offset   byte offset within the first word
//          i_wdata    right-aligned store data
//          i_rdata_lo first-beat read data
//          i_rdata_hi second-beat read data
//          o_mask     8-lane byte mask ([3:0] beat 0, [7:4] beat 1)
//          o_wdata    lane-aligned store data ([31:0] beat 0, [63:32] beat 1)
//          o_split    access needs a second beat
//          o_rdata    extended load result
module rv_go_lsu_align
  import rv_go_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_lo,
  input  logic [31:0] i_rdata_hi,
  output logic [7:0]  o_mask,
  output logic [63:0] o_wdata,
  output logic        o_split,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_base;
  logic [4:0]  w_shift;
  logic [31:0] w_rd;

  always_comb begin
    case (i_op[1:0])
      2'b00:   w_base = 8'h01;
      2'b01:   w_base = 8'h03;
      default: w_base = 8'h0F;
    endcase
  end

  assign w_shift = {i_offset, 3'b000};
  assign o_mask  = w_base << i_offset;
  // Any lane pushed past byte 3 lands in the next word.
  assign o_split = |o_mask[7:4];
  assign o_wdata = {32'd0, i_wdata} << w_shift;
  assign w_rd    = 32'({i_rdata_hi, i_rdata_lo} >> w_shift);

  always_comb begin
    case (i_op)
      MOP_B:   o_rdata = {{24{w_rd[7]}}, w_rd[7:0]};
      MOP_H:   o_rdata = {{16{w_rd[15]}}, w_rd[15:0]};
      MOP_W:   o_rdata = w_rd;
      MOP_BU:  o_rdata = {24'd0, w_rd[7:0]};
      MOP_HU:  o_rdata = {16'd0, w_rd[15:0]};
      default: o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv_go_lsu.sv
// rtl/rv_go_lsu.sv - M-stage load/store unit splitting misaligned accesses
// Purpose: turns one core memory access into one or two word bus beats,
//          stalls the core meanwhile, aborts beats that never get acked.
// Ports:   clk, rst               clock, synchronous active-high reset
//          mem_en/mem_w/mem_op    access valid, store flag, funct3
//          addr/wdata             byte address, right-aligned store data
//          rdata/stall/err        load result, core hold, error pulse
//          bus_req/bus_we         beat request and direction
//          bus_addr/bus_be        word address and byte enables
//          bus_wdata              lane-aligned write data
//          bus_ack/bus_rdata      beat completion and its read data
module rv_go_lsu
  import rv_go_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_w,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Last wait cycle a beat is allowed before it is abandoned.
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(BUS_TIMEOUT - 1);

  lsu_state_e             r_state;
  lsu_state_e             w_next;
  logic [31:0]            r_addr;
  logic [2:0]             r_op;
  logic [31:0]            r_wdata;
  logic                   r_we;
  logic [31:0]            r_beat0;
  logic [31:0]            r_rdata;
  logic                   r_err;
  logic [TMO_CNT_W-1:0]   r_cnt;

  logic                   w_legal;
  logic                   w_tmo;
  logic                   w_in_beat;
  logic [7:0]             w_mask;
  logic [63:0]            w_wdata64;
  logic                   w_split;
  logic [31:0]            w_ld_result;
  logic [31:0]            w_rdata_lo;
  logic [31:0]            w_beat_base;

  assign w_legal     = op_legal(mem_op, mem_w);
  assign w_in_beat   = (r_state == ST_BEAT0) || (r_state == ST_BEAT1);
  assign w_tmo       = w_in_beat && !bus_ack && (r_cnt == TMO_LAST);
  assign w_beat_base = {r_addr[31:2], 2'b00};
  // In BEAT1 the low half of the load comes from the captured first beat.
  assign w_rdata_lo  = (r_state == ST_BEAT1) ? r_beat0 : bus_rdata;

  rv_go_lsu_align u_align (
    .i_op       (r_op),
    .i_offset   (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_rdata_lo (w_rdata_lo),
    .i_rdata_hi (bus_rdata),
    .o_mask     (w_mask),
    .o_wdata    (w_wdata64),
    .o_split    (w_split),
    .o_rdata    (w_ld_result)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_op    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_beat0 <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (mem_en) begin
            r_addr  <= addr;
            r_op    <= mem_op;
            r_wdata <= wdata;
            r_we    <= mem_w;
            r_err   <= !w_legal;
            if (!w_legal) r_rdata <= '0;
          end
        end
        ST_BEAT0, ST_BEAT1: begin
          if (bus_ack) begin
            r_cnt <= '0;
            if (r_state == ST_BEAT0) r_beat0 <= bus_rdata;
            if (!r_we && (w_next == ST_DONE)) r_rdata <= w_ld_result;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        default: r_err <= 1'b0;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_en) w_next = w_legal ? ST_BEAT0 : ST_DONE;
      end
      ST_BEAT0: begin
        if (bus_ack)    w_next = w_split ? ST_BEAT1 : ST_DONE;
        else if (w_tmo) w_next = ST_DONE;
      end
      ST_BEAT1: begin
        if (bus_ack || w_tmo) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus_req   = w_in_beat;
    bus_we    = w_in_beat && r_we;
    bus_addr  = 32'd0;
    bus_be    = 4'd0;
    bus_wdata = 32'd0;
    if (r_state == ST_BEAT0) begin
      bus_addr  = w_beat_base;
      bus_be    = w_mask[3:0];
      bus_wdata = r_we ? w_wdata64[31:0] : 32'd0;
    end else if (r_state == ST_BEAT1) begin
      bus_addr  = w_beat_base + 32'd4;
      bus_be    = w_mask[7:4];
      bus_wdata = r_we ? w_wdata64[63:32] : 32'd0;
    end
    stall = ((r_state == ST_IDLE) && mem_en) || w_in_beat;
    err   = (r_state == ST_DONE) && r_err;
    rdata = r_rdata;
  end

endmodule
